// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: data width, register-index width and the
// hardwired-zero register index.
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREG_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT   = $clog2(NREG_DEFAULT);
  localparam int unsigned REG_ZERO     = 0;

  typedef logic [AW_DEFAULT-1:0]   reg_idx_t;
  typedef logic [XLEN_DEFAULT-1:0] xlen_t;

endpackage : rv_pkg

// File: rtl/rf_word.sv
// One architectural register: W-bit flop with write enable and a synchronous
// active-low clear that takes priority over the write.
module rf_word #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule : rf_word

// File: rtl/register_file.sv
// Integer register file: two combinational read ports with optional write
// bypass, one synchronous write port, and an unbypassed debug read port.
module register_file
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREG   = NREG_DEFAULT,
  parameter int unsigned AW     = $clog2(NREG),
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic [AW-1:0]   dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
);

  logic [XLEN-1:0] word_q [NREG];

  // x0 has no storage; it reads as a constant zero.
  assign word_q[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_word
    logic word_we;
    assign word_we = wr_en_i && (rd_addr_i == AW'(i));

    rf_word #(
      .W (XLEN)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .we  (word_we),
      .d   (rd_data_i),
      .q   (word_q[i])
    );
  end

  // Source read ports; bypass forwards write data to a same-cycle read.
  always_comb begin
    rs1_data_o = word_q[rs1_addr_i];
    if (rs1_addr_i == AW'(REG_ZERO)) begin
      rs1_data_o = '0;
    end else if (BYPASS && wr_en_i && (rd_addr_i == rs1_addr_i)) begin
      rs1_data_o = rd_data_i;
    end
  end

  always_comb begin
    rs2_data_o = word_q[rs2_addr_i];
    if (rs2_addr_i == AW'(REG_ZERO)) begin
      rs2_data_o = '0;
    end else if (BYPASS && wr_en_i && (rd_addr_i == rs2_addr_i)) begin
      rs2_data_o = rd_data_i;
    end
  end

  // Debug port always shows the stored (pre-edge) value.
  always_comb begin
    dbg_data_o = word_q[dbg_addr_i];
    if (dbg_addr_i == AW'(REG_ZERO)) begin
      dbg_data_o = '0;
    end
  end

endmodule : register_file
